// File: rtl/bus_source_sequencer.sv
// rtl/bus_source_sequencer.sv - one-hot bus-drive grant sequencer feeding the bus-select encoder
//
// Purpose:
//   Accepts a multi-bit request mask and walks it lowest index first,
//   presenting one registered one-hot grant per cycle to the 32-to-5
//   bus-select encoder. Zero grant means no driver on the bus.
//
// Optional feature (macro BUS_SEQ_COUNT_EN):
//   Adds output grant_count, the number of grants issued for the
//   current/most recent request.
//
// Ports:
//   clock        in   rising-edge clock
//   clear_n      in   synchronous active-low reset
//   req_valid    in   request mask presented
//   req_mask     in   [MASK_W-1:0] sources to drive, one bus cycle each
//   req_ready    out  request can be accepted (IDLE only)
//   stall        in   hold current grant, do not advance
//   grant        out  [MASK_W-1:0] registered one-hot source select, zero when idle
//   grant_valid  out  grant is non-zero this cycle
//   done         out  one-cycle pulse after the last grant of a request
//   err_req      out  one-cycle pulse when a request has no legal bits
//   grant_count  out  [5:0] grants issued (BUS_SEQ_COUNT_EN only)

module bus_source_sequencer #(
  parameter int NUM_SRC = 24,
  parameter int MASK_W  = 32
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              req_valid,
  input  logic [MASK_W-1:0] req_mask,
  output logic              req_ready,
  input  logic              stall,
  output logic [MASK_W-1:0] grant,
  output logic              grant_valid,
  output logic              done,
`ifdef BUS_SEQ_COUNT_EN
  output logic [5:0]        grant_count,
`endif
  output logic              err_req
);

  // Bits [NUM_SRC-1:0] are legal sources; anything above is discarded.
  function automatic logic [MASK_W-1:0] legal_bits();
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < NUM_SRC) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [MASK_W-1:0] LEGAL_MASK = legal_bits();
  localparam logic [MASK_W-1:0] ONE        = MASK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [MASK_W-1:0] pending;

  logic [MASK_W-1:0] legal;
  logic [MASK_W-1:0] legal_low;
  logic [MASK_W-1:0] pend_low;

  // x & -x isolates the lowest set bit, giving the lowest-index-first order.
  always_comb begin
    legal     = req_mask & LEGAL_MASK;
    legal_low = legal & (~legal + ONE);
    pend_low  = pending & (~pending + ONE);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      done        <= 1'b0;
      err_req     <= 1'b0;
      req_ready   <= 1'b1;
`ifdef BUS_SEQ_COUNT_EN
      grant_count <= 6'd0;
`endif
    end else begin
      done    <= 1'b0;
      err_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (legal != '0) begin
              // First grant is issued on the accepting edge itself.
              grant       <= legal_low;
              grant_valid <= 1'b1;
              pending     <= legal & ~legal_low;
              req_ready   <= 1'b0;
              state       <= ST_GRANT;
`ifdef BUS_SEQ_COUNT_EN
              grant_count <= 6'd1;
`endif
            end else begin
              err_req <= 1'b1;
            end
          end
        end

        ST_GRANT: begin
          if (!stall) begin
            if (pending != '0) begin
              grant   <= pend_low;
              pending <= pending & ~pend_low;
`ifdef BUS_SEQ_COUNT_EN
              grant_count <= grant_count + 6'd1;
`endif
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // req_ready rises only now, so a request seen during DONE is not taken.
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          pending     <= '0;
          req_ready   <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_sequencer.sv
// tb/tb_bus_source_sequencer.sv - directed self-checking bench for bus_source_sequencer

module tb_bus_source_sequencer;

  logic        clock;
  logic        clear_n;
  logic        req_valid;
  logic [31:0] req_mask;
  logic        req_ready;
  logic        stall;
  logic [31:0] grant;
  logic        grant_valid;
  logic        done;
  logic        err_req;
`ifdef BUS_SEQ_COUNT_EN
  logic [5:0]  grant_count;
`endif

  int errors;
  int checks;
  bit inv_on;

  bus_source_sequencer #(.NUM_SRC(24), .MASK_W(32)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .req_valid   (req_valid),
    .req_mask    (req_mask),
    .req_ready   (req_ready),
    .stall       (stall),
    .grant       (grant),
    .grant_valid (grant_valid),
    .done        (done),
`ifdef BUS_SEQ_COUNT_EN
    .grant_count (grant_count),
`endif
    .err_req     (err_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream encoder model: index of the single set bit, 31 when zero.
  function automatic logic [31:0] enc(input logic [31:0] g);
    logic [31:0] code;
    code = 32'd31;
    for (int i = 0; i < 32; i++) begin
      if (g[i]) code = i;
    end
    return code;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_state(input string tag);
    check({tag, ".grant"}, grant, 32'h0);
    check({tag, ".gv"}, {31'd0, grant_valid}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".err"}, {31'd0, err_req}, 32'd0);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  always @(negedge clock) begin
    if (inv_on) begin
      check("inv.onehot", {31'd0, $onehot0(grant)}, 32'd1);
      check("inv.gv", {31'd0, grant_valid}, {31'd0, (grant != 32'h0)});
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    inv_on    = 1'b0;
    clear_n   = 1'b0;
    req_valid = 1'b0;
    req_mask  = 32'h0;
    stall     = 1'b0;

    step();
    step();
    idle_state("rst");
    clear_n = 1'b1;
    inv_on  = 1'b1;
    step();
    idle_state("rst_rel");

    // mask 0x5: grants 0x1, 0x4, then done, then ready
    req_valid = 1'b1;
    req_mask  = 32'h0000_0005;
    step();
    req_valid = 1'b0;
    check("t1.g0", grant, 32'h1);
    check("t1.enc0", enc(grant), 32'd0);
    check("t1.ready0", {31'd0, req_ready}, 32'd0);
    step();
    check("t1.g1", grant, 32'h4);
    check("t1.enc1", enc(grant), 32'd2);
    step();
    check("t1.g2", grant, 32'h0);
    check("t1.enc2", enc(grant), 32'd31);
    check("t1.done", {31'd0, done}, 32'd1);
    check("t1.ready2", {31'd0, req_ready}, 32'd0);
    step();
    idle_state("t1.end");

    // full legal mask: 24 back-to-back grants
    req_valid = 1'b1;
    req_mask  = 32'h00FF_FFFF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] exp_g;
      exp_g = 32'h1 << i;
      check("t2.g", grant, exp_g);
      step();
    end
    check("t2.end_g", grant, 32'h0);
    check("t2.done", {31'd0, done}, 32'd1);
`ifdef BUS_SEQ_COUNT_EN
    check("t2.count", {26'd0, grant_count}, 32'd24);
`endif
    step();
    idle_state("t2.end");

    // only illegal bits: error pulse, nothing granted
    req_valid = 1'b1;
    req_mask  = 32'hFF00_0000;
    step();
    req_valid = 1'b0;
    check("t3.err", {31'd0, err_req}, 32'd1);
    check("t3.grant", grant, 32'h0);
    check("t3.ready", {31'd0, req_ready}, 32'd1);
    step();
    idle_state("t3.after");

    // mixed: illegal high bits dropped, single grant 0x1
    req_valid = 1'b1;
    req_mask  = 32'h8100_0001;
    step();
    req_valid = 1'b0;
    check("t3b.g", grant, 32'h1);
    check("t3b.err", {31'd0, err_req}, 32'd0);
    step();
    check("t3b.g_end", grant, 32'h0);
    check("t3b.done", {31'd0, done}, 32'd1);
    step();
    idle_state("t3b.end");

    // stall for 3 cycles during grant 0x100
    req_valid = 1'b1;
    req_mask  = 32'h0000_0300;
    step();
    req_valid = 1'b0;
    stall     = 1'b1;
    check("t4.g0", grant, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4.hold", grant, 32'h100);
      check("t4.hold_done", {31'd0, done}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t4.g1", grant, 32'h200);
    step();
    check("t4.g_end", grant, 32'h0);
    check("t4.done", {31'd0, done}, 32'd1);
`ifdef BUS_SEQ_COUNT_EN
    check("t4.count", {26'd0, grant_count}, 32'd2);
`endif
    step();
    idle_state("t4.end");
`ifdef BUS_SEQ_COUNT_EN
    check("t4.count_hold", {26'd0, grant_count}, 32'd2);
`endif

    // reset while grant=0x10 mid-sequence
    req_valid = 1'b1;
    req_mask  = 32'h0000_003C;
    step();
    req_valid = 1'b0;
    check("t5.g0", grant, 32'h4);
    step();
    check("t5.g1", grant, 32'h8);
    step();
    check("t5.g2", grant, 32'h10);
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    idle_state("t5.rst");
    step();
    idle_state("t5.post");
    req_valid = 1'b1;
    req_mask  = 32'h0000_0006;
    step();
    req_valid = 1'b0;
    check("t5.fresh0", grant, 32'h2);
    step();
    check("t5.fresh1", grant, 32'h4);
    step();
    check("t5.fresh_done", {31'd0, done}, 32'd1);
    step();
    idle_state("t5.end");

    // req_valid held through GRANT and DONE with a new mask
    req_valid = 1'b1;
    req_mask  = 32'h0000_0003;
    step();
    req_mask  = 32'h0000_0040;
    check("t6.g0", grant, 32'h1);
    step();
    check("t6.g1", grant, 32'h2);
    step();
    check("t6.done", {31'd0, done}, 32'd1);
    check("t6.ready_done", {31'd0, req_ready}, 32'd0);
    step();
    check("t6.idle_g", grant, 32'h0);
    check("t6.idle_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("t6.new_g", grant, 32'h40);
    check("t6.new_ready", {31'd0, req_ready}, 32'd0);
`ifdef BUS_SEQ_COUNT_EN
    check("t6.count", {26'd0, grant_count}, 32'd1);
`endif
    step();
    check("t6.new_done", {31'd0, done}, 32'd1);
    step();
    idle_state("t6.end");

    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
